// File: rtl/axi_slave_pkg.sv
// Shared types for the dot-product accelerator control slave: FSM states,
// default bus widths and the job descriptor layout.
package axi_slave_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_READ    = 3'd4
  } state_e;

  // The descriptor is sized by the package defaults; overriding the module
  // widths means changing these defaults as well.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [ADDR_W_DEF-1:0] addr_a;
    logic [ADDR_W_DEF-1:0] addr_b;
    logic [ADDR_W_DEF-1:0] addr_out;
    logic [ADDR_W_DEF-1:0] len;
  } desc_t;

endpackage

// File: rtl/axi_slave_desc_mux.sv
// Combinational source select for the job descriptor: slave-side (*_s)
// inputs when sel_s=1, master-side (*_ms) inputs otherwise.
module axi_slave_desc_mux
  import axi_slave_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              sel_s,
  input  logic [DATA_W-1:0] vector_a_s,
  input  logic [DATA_W-1:0] vector_b_s,
  input  logic [ADDR_W-1:0] vector_a_addr_s,
  input  logic [ADDR_W-1:0] vector_b_addr_s,
  input  logic [ADDR_W-1:0] output_addr_s,
  input  logic [ADDR_W-1:0] vector_len_s,
  input  logic [DATA_W-1:0] wdata_a_ms,
  input  logic [DATA_W-1:0] wdata_b_ms,
  input  logic [ADDR_W-1:0] waddr_a_ms,
  input  logic [ADDR_W-1:0] waddr_b_ms,
  input  logic [ADDR_W-1:0] waddr_output_ms,
  input  logic [ADDR_W-1:0] vector_len_o_ms,
  output desc_t             desc
);

  always_comb begin
    if (sel_s) begin
      desc.a        = vector_a_s;
      desc.b        = vector_b_s;
      desc.addr_a   = vector_a_addr_s;
      desc.addr_b   = vector_b_addr_s;
      desc.addr_out = output_addr_s;
      desc.len      = vector_len_s;
    end else begin
      desc.a        = wdata_a_ms;
      desc.b        = wdata_b_ms;
      desc.addr_a   = waddr_a_ms;
      desc.addr_b   = waddr_b_ms;
      desc.addr_out = waddr_output_ms;
      desc.len      = vector_len_o_ms;
    end
  end

endmodule

// File: rtl/axi_slave.sv
// Control slave for the dot-product accelerator: latches a job descriptor and
// sequences it through fetch, compute, write-back and read-back.
module axi_slave
  import axi_slave_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] vector_a_s,
  input  logic [DATA_W-1:0] vector_b_s,
  input  logic [ADDR_W-1:0] vector_a_addr_s,
  input  logic [ADDR_W-1:0] vector_b_addr_s,
  input  logic [ADDR_W-1:0] vector_len_s,
  input  logic [ADDR_W-1:0] output_addr_s,
  input  logic [ADDR_W-1:0] read_data_addr_s,
  input  logic              master_to_slave,
  input  logic [DATA_W-1:0] read_data,
  input  logic              status,
  input  logic              processing_done,
  input  logic              store_done,
  input  logic              read_done,
  output logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] wdata_a_ms,
  input  logic [DATA_W-1:0] wdata_b_ms,
  input  logic [ADDR_W-1:0] waddr_a_ms,
  input  logic [ADDR_W-1:0] waddr_b_ms,
  input  logic [ADDR_W-1:0] waddr_output_ms,
  input  logic [ADDR_W-1:0] vector_len_o_ms,
  output logic [DATA_W-1:0] wdata_a_sm,
  output logic [DATA_W-1:0] wdata_b_sm,
  output logic [ADDR_W-1:0] waddr_a_sm,
  output logic [ADDR_W-1:0] waddr_b_sm,
  output logic [ADDR_W-1:0] waddr_output_sm,
  output logic [ADDR_W-1:0] vector_len_o_sm,
  output logic              start_fetch,
  output logic              start_compute,
  output logic              start_write,
  output logic              start_read,
  output logic              wdvalid,
  output logic              awvalid
);

  state_e            state_q, state_d;
  desc_t             desc_q, desc_d, desc_sel;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // Kept for the downstream read path; it drives no output of this block.
  logic [ADDR_W-1:0] rd_addr_unused_q, rd_addr_unused_d;

  axi_slave_desc_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_desc_mux (
    .sel_s           (master_to_slave),
    .vector_a_s      (vector_a_s),
    .vector_b_s      (vector_b_s),
    .vector_a_addr_s (vector_a_addr_s),
    .vector_b_addr_s (vector_b_addr_s),
    .output_addr_s   (output_addr_s),
    .vector_len_s    (vector_len_s),
    .wdata_a_ms      (wdata_a_ms),
    .wdata_b_ms      (wdata_b_ms),
    .waddr_a_ms      (waddr_a_ms),
    .waddr_b_ms      (waddr_b_ms),
    .waddr_output_ms (waddr_output_ms),
    .vector_len_o_ms (vector_len_o_ms),
    .desc            (desc_sel)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d          = state_q;
    desc_d           = desc_q;
    rdata_d          = rdata_q;
    rd_addr_unused_d = rd_addr_unused_q;
    start_fetch      = 1'b0;
    start_compute    = 1'b0;
    start_write      = 1'b0;
    start_read       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          desc_d           = desc_sel;
          rd_addr_unused_d = read_data_addr_s;
          state_d          = S_FETCH;
        end
      end
      S_FETCH: begin
        start_fetch = 1'b1;
        if (!status) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        start_compute = 1'b1;
        if (processing_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        start_write = 1'b1;
        if (store_done) state_d = S_READ;
      end
      S_READ: begin
        start_read = 1'b1;
        if (read_done) begin
          if (rvalid) rdata_d = read_data;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      // NOTE: descriptor and result registers are reset because their
      // outputs must read zero after reset, not merely be don't-care.
      desc_q           <= '0;
      rdata_q          <= '0;
      rd_addr_unused_q <= '0;
    end else begin
      state_q          <= state_d;
      desc_q           <= desc_d;
      rdata_q          <= rdata_d;
      rd_addr_unused_q <= rd_addr_unused_d;
    end
  end

  assign awvalid         = start_fetch;
  assign wdvalid         = start_fetch;
  assign rdata           = rdata_q;
  assign wdata_a_sm      = desc_q.a;
  assign wdata_b_sm      = desc_q.b;
  assign waddr_a_sm      = desc_q.addr_a;
  assign waddr_b_sm      = desc_q.addr_b;
  assign waddr_output_sm = desc_q.addr_out;
  assign vector_len_o_sm = desc_q.len;

endmodule

// File: tb/tb_axi_slave.sv
// Self-checking bench for axi_slave: directed vector table, hand-written
// corner sequences and randomized traffic against a stage-index model.
module tb_axi_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, master_to_slave, status;
  logic        processing_done, store_done, read_done, rvalid;
  logic [31:0] vector_a_s, vector_b_s, vector_a_addr_s, vector_b_addr_s;
  logic [31:0] vector_len_s, output_addr_s, read_data_addr_s, read_data;
  logic [31:0] wdata_a_ms, wdata_b_ms, waddr_a_ms, waddr_b_ms;
  logic [31:0] waddr_output_ms, vector_len_o_ms;
  logic [31:0] rdata, wdata_a_sm, wdata_b_sm, waddr_a_sm, waddr_b_sm;
  logic [31:0] waddr_output_sm, vector_len_o_sm;
  logic        start_fetch, start_compute, start_write, start_read;
  logic        wdvalid, awvalid;

  int checks = 0;
  int errors = 0;

  // Model: stage 0 idle, 1 fetch, 2 compute, 3 write-back, 4 read-back.
  int           m_stage;
  logic [191:0] m_desc;
  logic [31:0]  m_rdata;

  typedef struct {
    logic        start, m2s, status, pdone, sdone, rdone, rvalid;
    logic [31:0] rd;
    logic [3:0]  exp_en;     // {fetch, compute, write, read}
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  axi_slave dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .vector_a_s      (vector_a_s),
    .vector_b_s      (vector_b_s),
    .vector_a_addr_s (vector_a_addr_s),
    .vector_b_addr_s (vector_b_addr_s),
    .vector_len_s    (vector_len_s),
    .output_addr_s   (output_addr_s),
    .read_data_addr_s(read_data_addr_s),
    .master_to_slave (master_to_slave),
    .read_data       (read_data),
    .status          (status),
    .processing_done (processing_done),
    .store_done      (store_done),
    .read_done       (read_done),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .wdata_a_ms      (wdata_a_ms),
    .wdata_b_ms      (wdata_b_ms),
    .waddr_a_ms      (waddr_a_ms),
    .waddr_b_ms      (waddr_b_ms),
    .waddr_output_ms (waddr_output_ms),
    .vector_len_o_ms (vector_len_o_ms),
    .wdata_a_sm      (wdata_a_sm),
    .wdata_b_sm      (wdata_b_sm),
    .waddr_a_sm      (waddr_a_sm),
    .waddr_b_sm      (waddr_b_sm),
    .waddr_output_sm (waddr_output_sm),
    .vector_len_o_sm (vector_len_o_sm),
    .start_fetch     (start_fetch),
    .start_compute   (start_compute),
    .start_write     (start_write),
    .start_read      (start_read),
    .wdvalid         (wdvalid),
    .awvalid         (awvalid)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] dut_desc();
    return {wdata_a_sm, wdata_b_sm, waddr_a_sm, waddr_b_sm, waddr_output_sm, vector_len_o_sm};
  endfunction

  function automatic logic [5:0] dut_en();
    return {start_fetch, awvalid, wdvalid, start_compute, start_write, start_read};
  endfunction

  // Expected {fetch, awvalid, wdvalid, compute, write, read} from a 4-bit stage vector.
  function automatic logic [5:0] widen(input logic [3:0] e);
    return {e[3], e[3], e[3], e[2:0]};
  endfunction

  function automatic logic [3:0] model_en();
    logic [3:0] one = 4'b1000;
    if (m_stage == 0) return 4'b0000;
    return one >> (m_stage - 1);
  endfunction

  task automatic model_reset();
    m_stage = 0;
    m_desc  = '0;
    m_rdata = '0;
  endtask

  // Applies the current inputs as seen at the next rising edge.
  task automatic model_step();
    case (m_stage)
      0: if (start) begin
           m_desc = master_to_slave
             ? {vector_a_s, vector_b_s, vector_a_addr_s, vector_b_addr_s, output_addr_s, vector_len_s}
             : {wdata_a_ms, wdata_b_ms, waddr_a_ms, waddr_b_ms, waddr_output_ms, vector_len_o_ms};
           m_stage = 1;
         end
      1: if (!status) m_stage = 2;
      2: if (processing_done) m_stage = 3;
      3: if (store_done) m_stage = 4;
      4: if (read_done) begin
           if (rvalid) m_rdata = read_data;
           m_stage = 0;
         end
      default: m_stage = 0;
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_en"}, {186'd0, dut_en()}, {186'd0, widen(model_en())});
    check({tag, "_rdata"}, {160'd0, rdata}, {160'd0, m_rdata});
    check({tag, "_desc"}, dut_desc(), m_desc);
  endtask

  task automatic clear_pulses();
    start = 0; status = 0; processing_done = 0; store_done = 0;
    read_done = 0; rvalid = 0; read_data = '0;
  endtask

  task automatic run_cycle(input string tag);
    model_step();
    tick();
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    clear_pulses();
    start = 1'b1;
    master_to_slave = 1'b1;
    vector_a_s = 32'd5;        vector_b_s = 32'd10;
    vector_a_addr_s = 32'h1000; vector_b_addr_s = 32'h2000;
    vector_len_s = 32'd4;      output_addr_s = 32'h3000;
    read_data_addr_s = 32'h4000;
    wdata_a_ms = 32'hdead;     wdata_b_ms = 32'hbeef;
    waddr_a_ms = 32'h11;       waddr_b_ms = 32'h22;
    waddr_output_ms = 32'h33;  vector_len_o_ms = 32'h44;
    model_reset();

    // Reset held with start=1: nothing may leave IDLE.
    repeat (3) tick();
    check("rst_en", {186'd0, dut_en()}, 192'd0);
    check("rst_rdata", {160'd0, rdata}, 192'd0);
    check("rst_desc", dut_desc(), 192'd0);
    rst = 1'b0;
    start = 1'b0;

    // Slave-source job with out-of-order and held done pulses.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  4'b1000, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  4'b0100, 32'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  4'b0100, 32'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  4'b0010, 32'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  4'b0010, 32'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  4'b0001, 32'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd50, 4'b0000, 32'd50};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  4'b0000, 32'd50};

    for (int i = 0; i < 8; i++) begin
      start           = vecs[i].start;
      master_to_slave = vecs[i].m2s;
      status          = vecs[i].status;
      processing_done = vecs[i].pdone;
      store_done      = vecs[i].sdone;
      read_done       = vecs[i].rdone;
      rvalid          = vecs[i].rvalid;
      read_data       = vecs[i].rd;
      model_step();
      tick();
      check($sformatf("vec%0d_en", i), {186'd0, dut_en()}, {186'd0, widen(vecs[i].exp_en)});
      check($sformatf("vec%0d_rdata", i), {160'd0, rdata}, {160'd0, vecs[i].exp_rdata});
    end
    check("slave_desc", dut_desc(),
          {32'd5, 32'd10, 32'h1000, 32'h2000, 32'h3000, 32'd4});
    clear_pulses();

    // Master-source job, then back-pressure in FETCH and a late start.
    wdata_a_ms = 32'd10; wdata_b_ms = 32'd11; waddr_a_ms = 32'd17;
    waddr_b_ms = 32'd18; waddr_output_ms = 32'd5; vector_len_o_ms = 32'd6;
    master_to_slave = 1'b0;
    start = 1'b1;
    run_cycle("ms_start");
    check("ms_desc", dut_desc(), {32'd10, 32'd11, 32'd17, 32'd18, 32'd5, 32'd6});
    start = 1'b0;
    status = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start = 1'b1;
        master_to_slave = 1'b1;
      end
      run_cycle($sformatf("hold%0d", i));
      check($sformatf("hold%0d_fetch", i), {191'd0, start_fetch}, 192'd1);
    end
    start = 1'b0;
    status = 1'b0;
    run_cycle("release");
    check("release_compute", {191'd0, start_compute}, 192'd1);
    processing_done = 1'b1;
    run_cycle("to_write");
    processing_done = 1'b0;
    check("ms_desc_held", dut_desc(), {32'd10, 32'd11, 32'd17, 32'd18, 32'd5, 32'd6});

    // Asynchronous abort during WRITE, away from the clock edge.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("abort_en", {186'd0, dut_en()}, 192'd0);
    check("abort_desc", dut_desc(), 192'd0);
    check("abort_rdata", {160'd0, rdata}, 192'd0);
    tick();
    rst = 1'b0;

    // Clean job after the abort.
    master_to_slave = 1'b1;
    start = 1'b1;
    run_cycle("post_start");
    start = 1'b0;
    run_cycle("post_fetch");
    processing_done = 1'b1;
    run_cycle("post_compute");
    processing_done = 1'b0;
    store_done = 1'b1;
    run_cycle("post_write");
    store_done = 1'b0;
    read_done = 1'b1;
    rvalid = 1'b1;
    read_data = 32'd77;
    run_cycle("post_read");
    check("post_rdata", {160'd0, rdata}, {160'd0, 32'd77});
    clear_pulses();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      start           = ($urandom_range(3) == 0);
      master_to_slave = $urandom_range(1);
      status          = ($urandom_range(2) == 0);
      processing_done = ($urandom_range(2) == 0);
      store_done      = ($urandom_range(2) == 0);
      read_done       = ($urandom_range(2) == 0);
      rvalid          = $urandom_range(1);
      read_data       = $urandom;
      vector_a_s = $urandom; vector_b_s = $urandom;
      vector_a_addr_s = $urandom; vector_b_addr_s = $urandom;
      vector_len_s = $urandom; output_addr_s = $urandom;
      read_data_addr_s = $urandom;
      wdata_a_ms = $urandom; wdata_b_ms = $urandom;
      waddr_a_ms = $urandom; waddr_b_ms = $urandom;
      waddr_output_ms = $urandom; vector_len_o_ms = $urandom;
      run_cycle($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave.md
Name: axi_slave

Overview:
- AXI-Lite-style control slave for the dot-product accelerator.
- Captures a job descriptor (operands, addresses, vector length) from one of two sources, forwards it to the datapath and sequences it through fetch → compute → write-back → read-back.
- Returns the read-back result on rdata.
- Sits between the host/AXI master and the fetch/compute/store engines.

Parameters:
- DATA_W, 32, width of operand and data buses.
- ADDR_W, 32, width of address and length buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- vector_a_s  in  DATA_W  slave-side operand A.
- vector_b_s  in  DATA_W  slave-side operand B.
- vector_a_addr_s  in  ADDR_W  slave-side address of vector A.
- vector_b_addr_s  in  ADDR_W  slave-side address of vector B.
- vector_len_s  in  ADDR_W  slave-side vector length.
- output_addr_s  in  ADDR_W  slave-side result address.
- read_data_addr_s  in  ADDR_W  read-back address; latched at job start, no output effect.
- master_to_slave  in  1  source select, sampled with start: 1 = *_s inputs, 0 = *_ms inputs.
- read_data  in  DATA_W  read-back data from the store engine.
- status  in  1  downstream busy; holds FETCH while 1.
- processing_done  in  1  compute-finished pulse.
- store_done  in  1  write-back-finished pulse.
- read_done  in  1  read-back-finished pulse.
- rdata  out  DATA_W  captured read-back result.
- rvalid  in  1  read_data qualifier.
- wdata_a_ms, wdata_b_ms  in  DATA_W  master-side operands A/B.
- waddr_a_ms, waddr_b_ms, waddr_output_ms  in  ADDR_W  master-side A/B/output addresses.
- vector_len_o_ms  in  ADDR_W  master-side vector length.
- wdata_a_sm, wdata_b_sm  out  DATA_W  latched operands A/B to the datapath.
- waddr_a_sm, waddr_b_sm, waddr_output_sm  out  ADDR_W  latched A/B/output addresses.
- vector_len_o_sm  out  ADDR_W  latched vector length.
- start_fetch, start_compute, start_write, start_read  out  1  stage enables.
- wdvalid, awvalid  out  1  write-data / write-address valid.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs, including *_sm, rdata and stage enables, are 0.
- State machine: IDLE, FETCH, COMPUTE, WRITE, READ.
  - IDLE: on rising clk with start=1, latch the descriptor and go to FETCH.
    - master_to_slave=1: wdata_a_sm←vector_a_s, wdata_b_sm←vector_b_s, waddr_a_sm←vector_a_addr_s, waddr_b_sm←vector_b_addr_s, waddr_output_sm←output_addr_s, vector_len_o_sm←vector_len_s.
    - master_to_slave=0: the same outputs take the corresponding *_ms inputs.
  - FETCH: start_fetch=awvalid=wdvalid=1. Leave to COMPUTE on the next edge with status=0; stay while status=1.
  - COMPUTE: start_compute=1; go to WRITE on an edge with processing_done=1.
  - WRITE: start_write=1; go to READ on an edge with store_done=1.
  - READ: start_read=1; on an edge with read_done=1, go to IDLE. If rvalid=1 on that same edge, rdata←read_data.
- Stage outputs are Moore, registered with the state: high exactly while in their state, low elsewhere.
- Done pulses arriving in any state other than their own are ignored and not remembered.
- start outside IDLE is ignored; the descriptor is not re-latched.
- *_sm outputs and rdata hold their values until the next latch or reset.
- Minimum latency from start to start_compute is 2 cycles when status=0.
- A done pulse held for several cycles advances exactly one state.
- Reset mid-job aborts to IDLE and clears everything.
- No arithmetic; all paths are pure register transfers of width DATA_W/ADDR_W.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FETCH, COMPUTE, WRITE, READ);
  - DATA_W/ADDR_W defaults;
  - a descriptor struct {a, b, addr_a, addr_b, addr_out, len}.
- One natural sub-module, axi_slave_desc_mux: combinational source select between *_s and *_ms, feeding the latch register.

Test Plan:
- Reset: assert rst with start=1 → all outputs 0, start_fetch stays 0.
- Slave-source job:
  - Stimulus: master_to_slave=1, vector_a_s=5, vector_b_s=10, addrs 0x1000/0x2000, len=4, out 0x3000, start pulse.
  - Response: wdata_a_sm=5, wdata_b_sm=10, waddr_a_sm=0x1000, waddr_b_sm=0x2000, vector_len_o_sm=4, waddr_output_sm=0x3000.
  - Sequencing: start_fetch/awvalid/wdvalid high one cycle, then start_compute until processing_done.
- Full sequence: processing_done, then store_done, then read_done+rvalid with read_data=50 → start_write, then start_read each asserted in turn; rdata=50; return to IDLE.
- Master-source job:
  - Stimulus: master_to_slave=0, wdata_a_ms=10, wdata_b_ms=11, waddr_a_ms=17, waddr_b_ms=18, waddr_output_ms=5, vector_len_o_ms=6.
  - Response: *_sm outputs equal 10/11/17/18/5/6.
- Out-of-order and back-pressure:
  - store_done during COMPUTE → ignored, FSM stays in COMPUTE.
  - status=1 in FETCH → FETCH held; released when status=0.
- Abort: rst asserted during WRITE → immediate IDLE, all outputs 0; a following start runs a clean job.
